rv_instr_encoder: RTL and testbench

- Streaming RV32I/M instruction encoder. It is the inverse of the core's field decoder.
- Accepts one instruction descriptor per handshake (format, opcode, funct3/funct7, register indices, 32-bit immediate) and emits packed 32-bit machine words.
- Expands the LI pseudo-op into LUI/ADDI sequences.
- Feeds the debug program-buffer injector and the boot self-test sequencer, which write code into instruction RAM.

---
 rtl/rv_instr_encoder.sv | 229 ++++++++++++++++++++++
 tb/tb_rv_instr_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_instr_encoder.sv
// ---------------------------------------------------------------------------
// rv_instr_encoder
//
// Purpose:
//   Streaming RV32I/M instruction encoder, the inverse of the core's field
//   decoder. It takes one instruction descriptor per handshake and emits
//   packed 32-bit machine words through a single registered output stage.
//   The LI pseudo-op expands into ADDI, LUI, or a LUI+ADDI pair. The
//   encoder feeds the debug program-buffer injector and the boot self-test
//   sequencer, which write code into instruction RAM.
//
// Configuration:
//   ENC_RANGE_CHECK_EN - when defined, the encoder rejects descriptors whose
//                        immediate does not fit the selected format. The
//                        reject looks exactly like fmt=7. When undefined,
//                        the encoder silently truncates out-of-range
//                        immediate bits and ignores imm[0] for B and J.
//
// Parameters:
//   CNT_W      - width of the emitted-word counter (wraps modulo 2^CNT_W)
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   descriptor valid
//   in_ready   out  descriptor accepted when in_valid & in_ready
//   in_fmt     in   0=R 1=I 2=S 3=B 4=U 5=J 6=LI 7=reserved (rejected)
//   in_opcode  in   opcode[6:0] (ignored for LI)
//   in_funct3  in   funct3 (ignored for U, J, LI)
//   in_funct7  in   funct7 (R only)
//   in_rd      in   rd index
//   in_rs1     in   rs1 index
//   in_rs2     in   rs2 index
//   in_imm     in   immediate / byte offset / full LI constant
//   out_valid  out  machine word valid
//   out_ready  in   sink accepts word
//   out_instr  out  encoded word
//   out_last   out  final word of the current descriptor's expansion
//   err_pulse  out  one-cycle pulse after a rejected descriptor is consumed
//   words_out  out  count of words accepted by the sink
// ---------------------------------------------------------------------------
module rv_instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_last,
  output logic             err_pulse,
  output logic [CNT_W-1:0] words_out
);

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_J  = 3'd5;
  localparam logic [2:0] FMT_LI = 3'd6;

  localparam logic [6:0] OPC_OPIMM = 7'h13;
  localparam logic [6:0] OPC_LUI   = 7'h37;

  typedef enum logic {
    S_IDLE,
    S_LI2
  } state_e;

  state_e           state_q, state_d;
  logic             outValid_q, outValid_d;
  logic [31:0]      outInstr_q, outInstr_d;
  logic             outLast_q, outLast_d;
  logic             errPulse_q, errPulse_d;
  logic [CNT_W-1:0] wordsOut_q, wordsOut_d;
  logic [31:0]      pendAddi_q, pendAddi_d;

  logic             accept;
  logic             consume;
  logic [31:0]      word0;
  logic [31:0]      word1;
  logic             last0;
  logic             twoWord;
  logic             reject;
  logic             immFits12;
  logic [19:0]      liUpper;

  // The output stage can take a new descriptor when idle and the current
  // word is absent or leaves this cycle. This term never depends on in_valid.
  assign in_ready = (state_q == S_IDLE) & (~outValid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign consume  = outValid_q & out_ready;

  assign out_valid = outValid_q;
  assign out_instr = outInstr_q;
  assign out_last  = outLast_q;
  assign err_pulse = errPulse_q;
  assign words_out = wordsOut_q;

  // A value fits signed 12 bits when bits [31:11] are all copies of the sign.
  assign immFits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);

  // This computes (K + 0x800) >> 12 without a 32-bit adder. Adding 0x800
  // carries into bit 12 exactly when K[11] is set, and the 20-bit sum wraps.
  assign liUpper = in_imm[31:12] + {19'd0, in_imm[11]};

  // Format-dependent packing of the descriptor into its first (and possibly
  // second) machine word, plus the reject decision for this descriptor.
  always_comb begin
    word0   = 32'd0;
    word1   = 32'd0;
    last0   = 1'b1;
    twoWord = 1'b0;
    reject  = 1'b0;
    case (in_fmt)
      FMT_R: word0 = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: word0 = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: word0 = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:0], in_opcode};
      FMT_B: word0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: word0 = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: word0 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                      in_rd, in_opcode};
      FMT_LI: begin
        if (immFits12) begin
          word0 = {in_imm[11:0], 5'd0, 3'd0, in_rd, OPC_OPIMM};
        end else if (in_imm[11:0] == 12'd0) begin
          word0 = {liUpper, in_rd, OPC_LUI};
        end else begin
          // The ADDI sign-extends its 12-bit field, which is why the LUI
          // half uses the rounded upper part computed in liUpper.
          word0   = {liUpper, in_rd, OPC_LUI};
          word1   = {in_imm[11:0], in_rd, 3'd0, in_rd, OPC_OPIMM};
          last0   = 1'b0;
          twoWord = 1'b1;
        end
      end
      default: reject = 1'b1;
    endcase
`ifdef ENC_RANGE_CHECK_EN
    case (in_fmt)
      FMT_I, FMT_S: if (!immFits12) reject = 1'b1;
      FMT_B: begin
        if (!((&in_imm[31:12]) | ~(|in_imm[31:12])) || in_imm[0]) begin
          reject = 1'b1;
        end
      end
      FMT_J: begin
        if (!((&in_imm[31:20]) | ~(|in_imm[31:20])) || in_imm[0]) begin
          reject = 1'b1;
        end
      end
      FMT_U: if (in_imm[11:0] != 12'd0) reject = 1'b1;
      default: ;
    endcase
`endif
  end

  // Next-state logic for the output stage and the LI expansion sequencer.
  // An accept always coincides with the old word leaving or being absent,
  // so a rejected descriptor simply lets the stage drain.
  always_comb begin
    state_d    = state_q;
    outValid_d = outValid_q;
    outInstr_d = outInstr_q;
    outLast_d  = outLast_q;
    pendAddi_d = pendAddi_q;
    errPulse_d = 1'b0;
    wordsOut_d = consume ? wordsOut_q + CNT_W'(1) : wordsOut_q;
    if (accept) begin
      if (reject) begin
        errPulse_d = 1'b1;
        outValid_d = 1'b0;
      end else begin
        outValid_d = 1'b1;
        outInstr_d = word0;
        outLast_d  = last0;
        if (twoWord) begin
          state_d    = S_LI2;
          pendAddi_d = word1;
        end
      end
    end else if (consume) begin
      if (state_q == S_LI2) begin
        // The held ADDI replaces the LUI on the same edge, with no bubble.
        outInstr_d = pendAddi_q;
        outLast_d  = 1'b1;
        outValid_d = 1'b1;
        state_d    = S_IDLE;
      end else begin
        outValid_d = 1'b0;
      end
    end
  end

  // All state and registered outputs. Reset discards any pending LI word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      outValid_q <= 1'b0;
      outInstr_q <= 32'd0;
      outLast_q  <= 1'b0;
      errPulse_q <= 1'b0;
      wordsOut_q <= '0;
      pendAddi_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      outValid_q <= outValid_d;
      outInstr_q <= outInstr_d;
      outLast_q  <= outLast_d;
      errPulse_q <= errPulse_d;
      wordsOut_q <= wordsOut_d;
      pendAddi_q <= pendAddi_d;
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_rv_instr_encoder
//
// Directed testbench for rv_instr_encoder. Expected words were worked out by
// hand from the RV32I field layouts. Inputs change on the falling edge, and
// outputs are sampled on the falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_rv_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err_pulse;
  logic [15:0] words_out;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expWords = 16'd0;

  rv_instr_encoder #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last),
    .err_pulse (err_pulse),
    .words_out (words_out)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison. A mismatch is counted and reported on a single line.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present one descriptor on a falling edge and hold it until the design
  // takes it. The task returns on the falling edge after the accept edge.
  task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] opc,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm);
    int waitCycles;
    in_fmt    = fmt;
    in_opcode = opc;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    in_valid  = 1'b1;
    waitCycles = 0;
    while (!in_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (in_ready) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
    end else begin
      in_valid = 1'b0;
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  // Check the word currently presented, then let the sink take it.
  task automatic expectWord(input string tag, input logic [31:0] instr,
                            input logic last);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_instr"}, out_instr, instr);
    checkOutput({tag, "_last"}, 32'(out_last), 32'(last));
    expWords++;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_fmt    = 3'd0;
    in_opcode = 7'd0;
    in_funct3 = 3'd0;
    in_funct7 = 7'd0;
    in_rd     = 5'd0;
    in_rs1    = 5'd0;
    in_rs2    = 5'd0;
    in_imm    = 32'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_err_pulse", 32'(err_pulse), 32'd0);
    checkOutput("rst_words_out", 32'(words_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

    // R-type: add x3,x1,x2
    applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    expectWord("r_add", 32'h002081B3, 1'b1);
    checkOutput("r_words_out", 32'(words_out), 32'(expWords));
    checkOutput("r_drained", 32'(out_valid), 32'd0);

    // B-type under backpressure: beq x1,x2,-4 is held for 5 cycles
    out_ready = 1'b0;
    applyStimulus(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) begin
      checkOutput("b_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("b_hold_instr", out_instr, 32'hFE208EE3);
      checkOutput("b_hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    checkOutput("b_hold_words", 32'(words_out), 32'(expWords));
    out_ready = 1'b1;
    expectWord("b_beq", 32'hFE208EE3, 1'b1);
    checkOutput("b_words_out", 32'(words_out), 32'(expWords));

    // LI two-word: rd5, K=0x12345FFF
    applyStimulus(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    checkOutput("li2_in_ready", 32'(in_ready), 32'd0);
    expectWord("li2_lui", 32'h123462B7, 1'b0);
    expectWord("li2_addi", 32'h FFF28293, 1'b1);
    checkOutput("li2_words_out", 32'(words_out), 32'(expWords));

    // LI single-word cases, including the signed 12-bit boundaries
    applyStimulus(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h0000_1000);
    expectWord("li_lui_only", 32'h000012B7, 1'b1);
    applyStimulus(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h0000_07FF);
    expectWord("li_max12", 32'h7FF00293, 1'b1);
    applyStimulus(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_F800);
    expectWord("li_min12", 32'h80000293, 1'b1);
    applyStimulus(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h8000_0000);
    expectWord("li_msb_lui", 32'h800002B7, 1'b1);

    // LI just outside the range: 2048 becomes LUI 1 then ADDI -2048
    applyStimulus(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h0000_0800);
    expectWord("li_2048_lui", 32'h000012B7, 1'b0);
    expectWord("li_2048_addi", 32'h80028293, 1'b1);

    // LI with rd=0 is still encoded as a normal pair
    applyStimulus(3'd6, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h12345678);
    expectWord("li_x0_lui", 32'h12345037, 1'b0);
    expectWord("li_x0_addi", 32'h67800013, 1'b1);

    // Remaining formats: sw x3,8(x2) / lui x1,0x12345 / jal x1,8 / addi x1,x0,-1
    applyStimulus(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd3, 32'd8);
    expectWord("s_sw", 32'h00312423, 1'b1);
    applyStimulus(3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345000);
    expectWord("u_lui", 32'h123450B7, 1'b1);
    applyStimulus(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
    expectWord("j_jal", 32'h008000EF, 1'b1);
    applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    expectWord("i_neg1", 32'hFFF00093, 1'b1);
    checkOutput("fmt_words_out", 32'(words_out), 32'(expWords));

    // Reserved format is consumed with a single error pulse and no word
    applyStimulus(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    checkOutput("f7_err_pulse", 32'(err_pulse), 32'd1);
    checkOutput("f7_no_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("f7_err_one_cycle", 32'(err_pulse), 32'd0);
    checkOutput("f7_words_out", 32'(words_out), 32'(expWords));

    // I-type imm=0x800 is out of range for 12 bits
    applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
`ifdef ENC_RANGE_CHECK_EN
    checkOutput("i800_err_pulse", 32'(err_pulse), 32'd1);
    checkOutput("i800_no_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
`else
    checkOutput("i800_err_pulse", 32'(err_pulse), 32'd0);
    expectWord("i800_trunc", 32'h80000093, 1'b1);
`endif

    // A reject accepted while the previous word leaves lets that word finish
    applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    checkOutput("sim_word_instr", out_instr, 32'h002081B3);
    expWords++;
    applyStimulus(3'd7, 7'h00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    checkOutput("sim_err_pulse", 32'(err_pulse), 32'd1);
    checkOutput("sim_no_valid", 32'(out_valid), 32'd0);
    checkOutput("sim_words_out", 32'(words_out), 32'(expWords));
    @(negedge clk);

    // Reset while an LI is parked in its second state with the LUI unconsumed
    out_ready = 1'b0;
    applyStimulus(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    checkOutput("rli_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rli_lui_held", out_instr, 32'h123462B7);
    rst_n = 1'b0;
    #1;
    checkOutput("rli_valid_cleared", 32'(out_valid), 32'd0);
    checkOutput("rli_words_cleared", 32'(words_out), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    expWords  = 16'd0;
    @(negedge clk);
    checkOutput("rli_idle_ready", 32'(in_ready), 32'd1);
    applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    expectWord("post_rst_r", 32'h002081B3, 1'b1);
    checkOutput("post_rst_words", 32'(words_out), 32'(expWords));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
